// File: rtl/decode_stage_hz.sv
// Decode stage: regfile with bypass, forwarding, load-use interlock, branch resolve, ID/EX register.
// Define DECODE_BRANCH_FULL_EN to also resolve blt/bge/bltu/bgeu.
module decode_stage_hz #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     instruccion,
    input  logic [XLEN-1:0] PCmas4,
    input  logic            reg_write_signal,
    input  logic [4:0]      write_reg,
    input  logic [XLEN-1:0] write_data,
    input  logic [4:0]      dir_Rd_EXE,
    input  logic            exe_regwrite,
    input  logic            exe_memread,
    input  logic [XLEN-1:0] dato_EXE,
    input  logic [4:0]      dir_Rd_MEM,
    input  logic            mem_regwrite,
    input  logic [XLEN-1:0] dato_MEM,
    output logic            stall_if,
    output logic            flush_if,
    output logic            Select_PC,
    output logic [XLEN-1:0] dir_salto,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_rs1,
    output logic [XLEN-1:0] ex_rs2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic            ex_alusrc,
    output logic [2:0]      ex_aluctrl,
    output logic [1:0]      ex_memctrl
);
    localparam logic [5:0] NR  = 6'(NREGS);
    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] SLL = 3'b101;
    localparam logic [2:0] SRL = 3'b110;
    localparam logic [2:0] SLT = 3'b111;

    logic [XLEN-1:0] rf [32];
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rs1, rs2, rd;
    logic            is_r, is_i, is_ld, is_st, is_br, known, use_rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;
    logic [4:0]      src [2];
    logic [XLEN-1:0] opv [2];
    logic            ld_hit, br_cond, taken;
    logic [2:0]      alu_f3;

    assign opc = instruccion[6:0];
    assign rd  = instruccion[11:7];
    assign f3  = instruccion[14:12];
    assign rs1 = instruccion[19:15];
    assign rs2 = instruccion[24:20];

    assign is_r    = opc == 7'b0110011;
    assign is_i    = opc == 7'b0010011;
    assign is_ld   = opc == 7'b0000011;
    assign is_st   = opc == 7'b0100011;
    assign is_br   = opc == 7'b1100011;
    assign known   = is_r | is_i | is_ld | is_st | is_br;
    assign use_rs2 = is_r | is_st | is_br;

    assign imm_i = {{(XLEN-11){instruccion[31]}}, instruccion[30:20]};
    assign imm_s = {{(XLEN-11){instruccion[31]}}, instruccion[30:25],
                    instruccion[11:7]};
    assign imm_b = {{(XLEN-12){instruccion[31]}}, instruccion[7],
                    instruccion[30:25], instruccion[11:8], 1'b0};

    assign src[0] = rs1;
    assign src[1] = rs2;

    // Youngest producer wins; a load in EXE has no data yet and is left to the interlock.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            opv[k] = '0;
            if (src[k] == 5'd0 || {1'b0, src[k]} >= NR)
                opv[k] = '0;
            else if (exe_regwrite && !exe_memread && dir_Rd_EXE == src[k])
                opv[k] = dato_EXE;
            else if (mem_regwrite && dir_Rd_MEM == src[k])
                opv[k] = dato_MEM;
            else if (reg_write_signal && write_reg == src[k])
                opv[k] = write_data;
            else
                opv[k] = rf[src[k]];
        end
    end

    assign ld_hit = if_valid && known && exe_memread && dir_Rd_EXE != 5'd0 &&
                    (dir_Rd_EXE == rs1 || (use_rs2 && dir_Rd_EXE == rs2));

    always_comb begin
        br_cond = 1'b0;
        case (f3)
            3'b000:  br_cond = opv[0] == opv[1];
            3'b001:  br_cond = opv[0] != opv[1];
`ifdef DECODE_BRANCH_FULL_EN
            3'b100:  br_cond = $signed(opv[0]) <  $signed(opv[1]);
            3'b101:  br_cond = $signed(opv[0]) >= $signed(opv[1]);
            3'b110:  br_cond = opv[0] <  opv[1];
            3'b111:  br_cond = opv[0] >= opv[1];
`endif
            default: br_cond = 1'b0;
        endcase
    end

    assign taken     = !reset && if_valid && is_br && !ld_hit && br_cond;
    assign stall_if  = !reset && ld_hit;
    assign flush_if  = taken;
    assign Select_PC = taken;
    assign dir_salto = PCmas4 + imm_b;

    always_comb begin
        alu_f3 = ADD;
        case (f3)
            3'b000:  alu_f3 = (is_r && instruccion[30]) ? SUB : ADD;
            3'b001:  alu_f3 = SLL;
            3'b010:  alu_f3 = SLT;
            3'b011:  alu_f3 = SLT;
            3'b100:  alu_f3 = XOR;
            3'b101:  alu_f3 = SRL;
            3'b110:  alu_f3 = OR;
            default: alu_f3 = AND;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) rf[k] <= '0;
        end else if (reg_write_signal && write_reg != 5'd0 &&
                     {1'b0, write_reg} < NR) begin
            rf[write_reg] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !if_valid || ld_hit || !known) begin
            ex_valid    <= 1'b0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_regwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_aluctrl  <= '0;
            ex_memctrl  <= 2'b00;
        end else begin
            ex_valid    <= 1'b1;
            ex_rs1      <= opv[0];
            ex_rs2      <= opv[1];
            ex_imm      <= is_st ? imm_s : ((is_i | is_ld) ? imm_i : '0);
            ex_rd       <= (is_r | is_i | is_ld) ? rd : 5'd0;
            ex_regwrite <= is_r | is_i | is_ld;
            ex_alusrc   <= is_i | is_ld | is_st;
            ex_aluctrl  <= (is_r | is_i) ? alu_f3 : (is_br ? SUB : ADD);
            ex_memctrl  <= is_ld ? 2'b01 : (is_st ? 2'b10 : 2'b00);
        end
    end
endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised successor to the existing decode stage: a registered decode stage with built-in ID/EX pipeline register.
- Integrates the register file (with write-through bypass), EXE/MEM/WB forwarding, load-use interlock, and in-decode branch resolution with fetch flush.
- Sits between the IF/ID register and EXE, and drives all stall/flush control towards fetch.

Parameters:
- XLEN, 32, datapath and register width in bits.
- NREGS, 32, number of architectural registers (2..32). Register index >= NREGS reads 0 and ignores writes.

Ports:
- clk  in  1  processor clock
- reset  in  1  synchronous, active-high; clears register file and ID/EX register
- if_valid  in  1  instruccion/PCmas4 hold a valid instruction
- instruccion  in  32  RV32 instruction word
- PCmas4  in  XLEN  PC+4 of the instruction
- reg_write_signal  in  1  WB write enable
- write_reg  in  5  WB destination
- write_data  in  XLEN  WB data
- dir_Rd_EXE  in  5  rd of instruction in EXE
- exe_regwrite  in  1  EXE instruction writes rd
- exe_memread  in  1  EXE instruction is a load
- dato_EXE  in  XLEN  EXE ALU result
- dir_Rd_MEM  in  5  rd in MEM
- mem_regwrite  in  1  MEM instruction writes rd
- dato_MEM  in  XLEN  MEM result (ALU or load data)
- stall_if  out  1  hold PC and IF/ID register (combinational)
- flush_if  out  1  squash IF/ID contents (combinational)
- Select_PC  out  1  1 = next PC is dir_salto (combinational)
- dir_salto  out  XLEN  PCmas4 + sign-extended B-immediate
- ex_valid  out  1  ID/EX holds a real instruction
- ex_rs1, ex_rs2  out  XLEN  forwarded operands (registered)
- ex_imm  out  XLEN  sign-extended I/S immediate (registered)
- ex_rd  out  5  destination (registered)
- ex_regwrite, ex_alusrc  out  1  controls (registered)
- ex_aluctrl  out  3  ALU operation (registered)
- ex_memctrl  out  2  00 none, 01 load, 10 store (registered)

Behaviour:
- Decode:
  - 0110011 R: regwrite=1, alusrc=0.
  - 0010011 I-ALU: regwrite=1, alusrc=1, I-immediate.
  - 0000011 load: regwrite=1, alusrc=1, memctrl=01, I-immediate.
  - 0100011 store: alusrc=1, memctrl=10, S-immediate.
  - 1100011 branch: no writeback.
  - Any other opcode: bubble.
  - ALU codes: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110, SLT 111.
- Register file:
  - Written at posedge when reg_write_signal=1 and write_reg!=0.
  - x0 always reads 0.
- Operand selection, per source, highest priority first:
  - src==0 -> 0.
  - dir_Rd_EXE match with exe_regwrite && !exe_memread -> dato_EXE.
  - dir_Rd_MEM match with mem_regwrite -> dato_MEM.
  - write_reg match with reg_write_signal -> write_data.
  - Otherwise -> register file value.
  - The same values feed the branch comparator.
- Load-use stall:
  - Condition: if_valid && exe_memread && dir_Rd_EXE!=0 && dir_Rd_EXE equals a used source (rs1 for all formats; rs2 for R/store/branch).
  - Effect: stall_if=1, Select_PC=0, flush_if=0; ID/EX loads a bubble.
  - Lasts exactly 1 cycle for a single load.
- Branch: taken when if_valid, no stall, and:
  - beq with equal operands, or
  - bne with unequal operands.
  - On taken: Select_PC=1 and flush_if=1 in the same cycle.
  - The branch enters ID/EX with ex_valid=1 and regwrite=0.
- Bubble definition: ex_valid=0, ex_regwrite=0, ex_memctrl=00; other ID/EX fields are don't-care but are driven to 0.
- ID/EX register:
  - Loads every cycle; no external enable.
  - if_valid=0 -> bubble.
- Simultaneous events:
  - Stall overrides branch resolution.
  - WB write to the same register in the same cycle is visible through the bypass.
- Reset:
  - All registers and ID/EX outputs go to 0; combinational outputs follow.
  - Reset mid-stall clears the stall in the next cycle.

Optional Feature:
- Macro: DECODE_BRANCH_FULL_EN.
- Defined: funct3 100/101/110/111 resolve as blt/bge/bltu/bgeu using signed/unsigned XLEN compares.
- Undefined: those funct3 values are never taken; only beq/bne resolve.

Test Plan:
- Reset, then addi x1,x0,5 with if_valid=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_aluctrl=000, ex_alusrc=1, ex_regwrite=1.
- add x3,x1,x2 with dir_Rd_EXE=1, exe_regwrite=1, dato_EXE=0x10, and dir_Rd_MEM=1, dato_MEM=0x20 -> ex_rs1=0x10 (EXE wins over MEM).
- lw x4,0(x0) in EXE (exe_memread=1, dir_Rd_EXE=4), decode add x5,x4,x4 -> stall_if=1 for 1 cycle and bubble in ID/EX; next cycle operand taken from dato_MEM.
- beq x6,x7 with both forwarded 0x7 and PCmas4=0x104, imm=+8 -> Select_PC=1, flush_if=1, dir_salto=0x10C; bne with same operands -> Select_PC=0.
- WB writes x8=0xAB while decode reads x8 in the same cycle -> ex_rs1=0xAB; write to x0 -> later reads return 0.
- blt x1,x2 with x1=-1, x2=1 -> taken only when DECODE_BRANCH_FULL_EN is defined; not taken otherwise.
